// File: rtl/build_packet.sv
// Serialises one packet (dest, src, len, payload, XOR checksum) onto a 16-bit
// valid/ready link, fetching payload words from a local RAM with 1-cycle latency.
module build_packet #(
  parameter int WORD_WIDTH = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  input  logic [WORD_WIDTH-1:0] destinationID,
  input  logic [LEN_WIDTH-1:0]  payload_len,
  output logic                  rd_en,
  output logic [LEN_WIDTH-1:0]  rd_addr,
  input  logic [WORD_WIDTH-1:0] rd_data,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_ARM, S_IDLE, S_HDR, S_FETCH, S_LOAD, S_PAY, S_CSUM
  } state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] dest;
    logic [WORD_WIDTH-1:0] src;
    logic [LEN_WIDTH-1:0]  len;
  } hdr_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t                state, state_n;
  hdr_t                  hdr_q, hdr_n;
  logic [1:0]            cnt, cnt_n;
  logic [LEN_WIDTH-1:0]  idx, idx_n;
  logic [WORD_WIDTH-1:0] csum, csum_n;
  logic [WORD_WIDTH-1:0] tx_data_n;
  logic                  tx_valid_n, rd_en_n, busy_n, done_n;
  logic [LEN_WIDTH-1:0]  rd_addr_n;
  logic                  xfer;

  assign xfer = tx_valid & tx_ready;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state    <= S_ARM;
      hdr_q    <= '0;
      cnt      <= '0;
      idx      <= '0;
      csum     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      hdr_q    <= hdr_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      csum     <= csum_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
      rd_en    <= rd_en_n;
      rd_addr  <= rd_addr_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Every output is computed one cycle ahead here and registered above.
  always_comb begin
    state_n    = state;
    hdr_n      = hdr_q;
    cnt_n      = cnt;
    idx_n      = idx;
    csum_n     = csum;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    rd_en_n    = 1'b0;
    rd_addr_n  = rd_addr;
    busy_n     = busy;
    done_n     = done;
    case (state)
      S_ARM: begin
        if (en) begin
          done_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_IDLE: begin
        if (start) begin
          hdr_n      = '{dest: destinationID, src: MY_NODE_ID, len: payload_len};
          csum_n     = '0;
          idx_n      = '0;
          cnt_n      = '0;
          busy_n     = 1'b1;
          tx_valid_n = 1'b1;
          tx_data_n  = destinationID;
          state_n    = S_HDR;
        end
      end
      S_HDR: begin
        if (xfer) begin
          csum_n = csum ^ tx_data;
          case (cnt)
            2'd0: begin
              tx_data_n = hdr_q.src;
              cnt_n     = 2'd1;
            end
            2'd1: begin
              tx_data_n = {{(WORD_WIDTH-LEN_WIDTH){1'b0}}, hdr_q.len};
              cnt_n     = 2'd2;
            end
            default: begin
              if (hdr_q.len == '0) begin
                tx_data_n = csum ^ tx_data;
                state_n   = S_CSUM;
              end else begin
                // Drop valid before the read so the RAM is never read mid-word.
                tx_valid_n = 1'b0;
                rd_en_n    = 1'b1;
                rd_addr_n  = idx;
                state_n    = S_FETCH;
              end
            end
          endcase
        end
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        tx_data_n  = rd_data;
        tx_valid_n = 1'b1;
        state_n    = S_PAY;
      end
      S_PAY: begin
        if (xfer) begin
          csum_n = csum ^ tx_data;
          if (idx == hdr_q.len - ONE) begin
            tx_data_n = csum ^ tx_data;
            state_n   = S_CSUM;
          end else begin
            idx_n      = idx + ONE;
            tx_valid_n = 1'b0;
            rd_en_n    = 1'b1;
            rd_addr_n  = idx + ONE;
            state_n    = S_FETCH;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          tx_valid_n = 1'b0;
          busy_n     = 1'b0;
          done_n     = 1'b1;
          state_n    = S_ARM;
        end
      end
      default: state_n = S_ARM;
    endcase
  end

endmodule

// File: tb/tb_build_packet.sv
// Bench for build_packet: RAM model, link monitor and a packet-level reference model.
module tb_build_packet;

  logic        clock = 1'b0;
  logic        nrst = 1'b1;
  logic        en = 1'b0, start = 1'b0;
  logic [15:0] MY_NODE_ID = '0, destinationID = '0;
  logic [3:0]  payload_len = '0;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, done;

  build_packet #(.WORD_WIDTH(16), .LEN_WIDTH(4)) dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .MY_NODE_ID(MY_NODE_ID), .destinationID(destinationID), .payload_len(payload_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [15:0] ram [16];
  always @(posedge clock) if (rd_en) rd_data <= ram[rd_addr];

  // Link / RAM-port monitor
  logic [15:0] got[$];
  logic [3:0]  addrs[$];
  logic [15:0] exp_q[$];
  int cyc = 0, last_xfer = 0, first_v = -1, rd_cnt = 0;
  bit rd_while_valid = 0;
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (tx_valid && first_v < 0) first_v = cyc;
    if (tx_valid && tx_ready) begin got.push_back(tx_data); last_xfer = cyc; end
    if (rd_en) begin
      rd_cnt = rd_cnt + 1;
      addrs.push_back(rd_addr);
      if (tx_valid) rd_while_valid = 1;
    end
  end

  int n_tests = 0, n_fail = 0;
  logic [15:0] cur_d, cur_s;
  logic [3:0]  cur_l;

  task automatic clr_mon();
    got.delete(); addrs.delete(); rd_cnt = 0; first_v = -1; rd_while_valid = 0;
  endtask

  // Packet as a list of words, checksum folded over everything before it.
  task automatic make_exp(input logic [15:0] d, input logic [15:0] s, input logic [3:0] l);
    logic [15:0] c;
    exp_q.delete();
    exp_q.push_back(d); exp_q.push_back(s); exp_q.push_back({12'h0, l});
    for (int i = 0; i < int'(l); i++) exp_q.push_back(ram[i]);
    c = 16'h0;
    foreach (exp_q[i]) c = c ^ exp_q[i];
    exp_q.push_back(c);
  endtask

  function automatic int word_errs();
    int e = 0;
    if (got.size() != exp_q.size()) e++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic int addr_errs(input int l);
    int e = 0;
    if (addrs.size() != l) e++;
    for (int i = 0; i < addrs.size(); i++) if (int'(addrs[i]) != i) e++;
    return e;
  endfunction

  task automatic do_arm();
    en = 1'b1; @(negedge clock); en = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] d, input logic [15:0] s, input logic [3:0] l);
    cur_d = d; cur_s = s; cur_l = l;
    destinationID = d; MY_NODE_ID = s; payload_len = l; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    destinationID = 16'($urandom); MY_NODE_ID = 16'($urandom); payload_len = 4'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin to = 1'b0; break; end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2 nrst = 1'b0;
    #1 n_tests++;
    if ({rd_en, rd_addr, tx_data, tx_valid, busy, done} !== 24'h0) begin
      n_fail++; $display("FAIL reset_async outs=%h want 0", {rd_en, rd_addr, tx_data, tx_valid, busy, done});
    end
    @(negedge clock) nrst = 1'b1;
    ram[0] = 16'h1234; ram[1] = 16'h5678;
    do_arm(); do_start(16'h00AA, 16'h00BB, 4'd2);
    repeat (4) @(negedge clock);
    @(posedge clock) #3 nrst = 1'b0;
    #1 n_tests++;
    if ({rd_en, rd_addr, tx_data, tx_valid, busy, done} !== 24'h0) begin
      n_fail++; $display("FAIL reset_midpkt outs=%h want 0", {rd_en, rd_addr, tx_data, tx_valid, busy, done});
    end
    @(negedge clock) nrst = 1'b1;
    clr_mon();
    start = 1'b1; repeat (2) @(negedge clock); start = 1'b0;
    repeat (8) @(negedge clock);
    n_tests++;
    if (first_v >= 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_unarmed first_valid=%0d busy=%b want none/0", first_v, busy);
    end
  endtask

  task automatic test_basic();
    bit to;
    ram[0] = 16'hA0A0; ram[1] = 16'h0F0F;
    clr_mon(); do_arm(); do_start(16'h0012, 16'h0005, 4'd2);
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== 16'h0012) begin
      n_fail++; $display("FAIL start_latency valid=%b data=%h want 1/0012", tx_valid, tx_data);
    end
    wait_done(200, 1'b0, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL basic_timeout done=%b want 1", done); end
    n_tests++;
    if (cyc != last_xfer || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_timing cyc=%0d last=%0d busy=%b want equal/0", cyc, last_xfer, busy);
    end
    make_exp(16'h0012, 16'h0005, 4'd2);
    n_tests++;
    if (word_errs() != 0 || got.size() != 6 || got[5] !== 16'hAFBA) begin
      n_fail++; $display("FAIL basic_words n=%0d errs=%0d last=%h want 6/0/afba", got.size(), word_errs(), got[got.size()-1]);
    end
    n_tests++;
    if (addr_errs(2) != 0) begin n_fail++; $display("FAIL basic_rd_addr n=%0d want 2 seq 0,1", addrs.size()); end
    n_tests++;
    if (last_xfer - first_v != 9) begin
      n_fail++; $display("FAIL basic_duration got=%0d want 9", last_xfer - first_v);
    end
  endtask

  task automatic test_zero_len();
    bit to;
    clr_mon(); do_arm(); do_start(16'h0012, 16'h0005, 4'd0);
    wait_done(100, 1'b0, to);
    make_exp(16'h0012, 16'h0005, 4'd0);
    n_tests++;
    if (to || word_errs() != 0 || got[got.size()-1] !== 16'h0017) begin
      n_fail++; $display("FAIL zero_words to=%b n=%0d last=%h want 0/4/0017", to, got.size(), got[got.size()-1]);
    end
    n_tests++;
    if (rd_cnt != 0) begin n_fail++; $display("FAIL zero_rd_en count=%0d want 0", rd_cnt); end
    n_tests++;
    if (last_xfer - first_v != 3) begin n_fail++; $display("FAIL zero_duration got=%0d want 3", last_xfer - first_v); end
  endtask

  task automatic test_backpressure();
    bit to, h1, h2;
    h1 = 0; h2 = 0; to = 1;
    ram[0] = 16'hA0A0; ram[1] = 16'h0F0F;
    clr_mon(); do_arm(); do_start(16'h0012, 16'h0005, 4'd2);
    for (int i = 0; i < 300; i++) begin
      if (done) begin to = 0; break; end
      if (tx_valid && got.size() == 1 && !h1) begin
        h1 = 1; tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clock); n_tests++;
          if (tx_valid !== 1'b1 || tx_data !== 16'h0005) begin
            n_fail++; $display("FAIL bp_hdr_hold valid=%b data=%h want 1/0005", tx_valid, tx_data);
          end
        end
        tx_ready = 1'b1;
      end else if (tx_valid && got.size() == 4 && !h2) begin
        h2 = 1; tx_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge clock); n_tests++;
          if (tx_valid !== 1'b1 || tx_data !== 16'h0F0F) begin
            n_fail++; $display("FAIL bp_pay_hold valid=%b data=%h want 1/0f0f", tx_valid, tx_data);
          end
        end
        tx_ready = 1'b1;
      end
      @(negedge clock);
    end
    make_exp(16'h0012, 16'h0005, 4'd2);
    n_tests++;
    if (to || !h1 || !h2) begin n_fail++; $display("FAIL bp_reached to=%b h1=%b h2=%b want 0/1/1", to, h1, h2); end
    n_tests++;
    if (word_errs() != 0 || got[got.size()-1] !== 16'hAFBA) begin
      n_fail++; $display("FAIL bp_words errs=%0d last=%h want 0/afba", word_errs(), got[got.size()-1]);
    end
    n_tests++;
    if (rd_cnt != 2 || rd_while_valid) begin
      n_fail++; $display("FAIL bp_reads count=%0d rd_while_valid=%b want 2/0", rd_cnt, rd_while_valid);
    end
  endtask

  task automatic test_arm_done();
    bit to;
    int n;
    clr_mon();
    start = 1'b1; repeat (2) @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    n_tests++;
    if (first_v >= 0 || done !== 1'b1) begin
      n_fail++; $display("FAIL arm_start_ignored first_valid=%0d done=%b want none/1", first_v, done);
    end
    en = 1'b1; start = 1'b1; @(negedge clock); en = 1'b0; start = 1'b0;
    repeat (5) @(negedge clock);
    n_tests++;
    if (first_v >= 0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL arm_en_start first_valid=%0d done=%b busy=%b want none/0/0", first_v, done, busy);
    end
    ram[0] = 16'($urandom);
    do_start(16'($urandom), 16'($urandom), 4'd1);
    @(negedge clock);
    start = 1'b1; en = 1'b1; @(negedge clock); start = 1'b0; en = 1'b0;
    wait_done(100, 1'b0, to);
    make_exp(cur_d, cur_s, cur_l);
    n_tests++;
    if (to || word_errs() != 0) begin n_fail++; $display("FAIL arm_midpkt_words to=%b errs=%0d want 0/0", to, word_errs()); end
    n = got.size();
    repeat (8) @(negedge clock);
    n_tests++;
    if (got.size() != n || tx_valid !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL arm_no_queue words=%0d valid=%b done=%b want %0d/0/1", got.size(), tx_valid, done, n);
    end
  endtask

  task automatic test_reset_restart();
    bit to, seen;
    seen = 0;
    for (int i = 0; i < 16; i++) ram[i] = 16'($urandom);
    do_arm(); do_start(16'h3C3C, 16'h0007, 4'd3);
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clock); if (rd_en) seen = 1; end
    @(posedge clock) #2 nrst = 1'b0;
    #1 n_tests++;
    if (!seen || {rd_en, rd_addr, tx_data, tx_valid, busy, done} !== 24'h0) begin
      n_fail++; $display("FAIL rst_load seen=%b outs=%h want 1/0", seen, {rd_en, rd_addr, tx_data, tx_valid, busy, done});
    end
    @(negedge clock) nrst = 1'b1;
    ram[0] = 16'h1111; ram[1] = 16'h2222;
    clr_mon(); do_arm(); do_start(16'h0042, 16'h0007, 4'd2);
    wait_done(200, 1'b0, to);
    make_exp(16'h0042, 16'h0007, 4'd2);
    n_tests++;
    if (to || word_errs() != 0 || addr_errs(2) != 0) begin
      n_fail++; $display("FAIL rst_restart to=%b errs=%0d csum=%h want 0/0/%h", to, word_errs(), got[got.size()-1], exp_q[exp_q.size()-1]);
    end
  endtask

  task automatic test_random();
    bit to;
    logic [3:0] l;
    for (int p = 0; p < 8; p++) begin
      l = (p == 0) ? 4'd15 : 4'($urandom);
      for (int i = 0; i < 16; i++) ram[i] = 16'($urandom);
      clr_mon(); do_arm(); do_start(16'($urandom), 16'($urandom), l);
      wait_done(3000, 1'b1, to);
      make_exp(cur_d, cur_s, cur_l);
      n_tests++;
      if (to || word_errs() != 0) begin
        n_fail++; $display("FAIL rand_words pkt=%0d len=%0d to=%b errs=%0d want 0/0", p, l, to, word_errs());
      end
      n_tests++;
      if (addr_errs(int'(l)) != 0 || rd_while_valid) begin
        n_fail++; $display("FAIL rand_reads pkt=%0d n=%0d rd_while_valid=%b want %0d/0", p, addrs.size(), rd_while_valid, l);
      end
      n_tests++;
      if (cyc != last_xfer || busy !== 1'b0) begin
        n_fail++; $display("FAIL rand_done_timing pkt=%0d cyc=%0d last=%0d busy=%b", p, cyc, last_xfer, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_arm_done();
    test_reset_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
